alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have port clk  input  1  the single clock; all logic updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port cmd_valid  input  1  upstream command present.
REQ-005 The block SHALL have port cmd_ready  output  1  block can accept a command this cycle.
REQ-006 The block SHALL have port cmd_opcode  input  3  ALU opcode (000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 shift right).
REQ-007 The block SHALL have port cmd_a  input  8  first operand.
REQ-008 The block SHALL have port cmd_b  input  8  second operand.
REQ-009 The block SHALL have port operand1  output  8  registered operand to the ALU.
REQ-010 The block SHALL have port operand2  output  8  registered operand to the ALU.
REQ-011 The block SHALL have port opcode  output  3  registered opcode to the ALU.
REQ-012 The block SHALL have port issue_valid  output  1  high on the first cycle a command is presented to the ALU.
REQ-013 The block SHALL have port div_zero_err  output  1  one-cycle pulse when a divide-by-zero command is dropped.
REQ-014 The block SHALL have port err_count  output  8  saturating count of dropped commands.
REQ-015 The block SHALL have port fill  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Accept: a command SHALL be written into the FIFO when cmd_valid and cmd_ready are both high on a rising edge.
REQ-017 cmd_ready SHALL equal (fill < DEPTH), registered-state only; no combinational path from cmd_valid; a pop in the same cycle SHALL NOT make a full FIFO ready.
REQ-018 FIFO SHALL be first-in first-out with read/write pointers wrapping modulo DEPTH; a simultaneous push and pop SHALL leave fill unchanged.
REQ-019 FSM states SHALL be IDLE, ISSUE, HOLD.
REQ-020 IDLE: if fill > 0, pop the head entry; if head is valid, load operand1/operand2/opcode and go to ISSUE; else stay IDLE.
REQ-021 ISSUE: issue_valid SHALL be high for exactly this cycle; if opcode == 000 go to HOLD, else go to IDLE, or stay in ISSUE loading and popping the next entry if one is available.
REQ-022 HOLD: operands and opcode SHALL stay unchanged for one additional cycle (add carry needs two ALU clocks); issue_valid low; then return to IDLE.
REQ-023 Throughput SHALL be one command per cycle for non-add ops; an add SHALL occupy two cycles.
REQ-024 Latency from accept to issue_valid SHALL be 2 cycles when the FIFO is empty and the FSM is IDLE.
REQ-025 Divide-by-zero: a head entry with opcode 011 and b == 0 SHALL be popped and discarded, not loaded; div_zero_err SHALL pulse for the pop cycle.
REQ-026 err_count SHALL increment on each discard and saturate at 255.
REQ-027 operand1, operand2 and opcode SHALL hold their last issued values while no command is issued.
REQ-028 A discarded entry SHALL cost one cycle; the next valid entry SHALL load on the following cycle.

Reset
REQ-029 On rst high, the block SHALL clear the FIFO (fill 0, pointers 0), set the FSM to IDLE, and drive operand1, operand2, opcode, issue_valid, div_zero_err and err_count to 0; cmd_ready SHALL be 1 the cycle after reset releases.
REQ-030 Reset asserted mid-operation (including in HOLD) SHALL take priority over all pushes and pops in that cycle; in-flight commands SHALL be lost.

Verification
REQ-031 Push xor(0x0F,0xFF) into an empty FIFO -> two cycles later issue_valid=1, operand1=0x0F, operand2=0xFF, opcode=110.
REQ-032 Push add(200,100), then sub(5,3) back-to-back -> add held 2 cycles, issue_valid pulses spaced 2 cycles apart, sub issued third cycle.
REQ-033 Push DEPTH commands while issue is blocked by consecutive adds -> cmd_ready=0 at fill=DEPTH; push+pop at full leaves cmd_ready low that cycle.
REQ-034 Push div(9,0), then div(9,3) -> div_zero_err pulse, err_count=1, only div(9,3) issued.
REQ-035 Assert rst during HOLD with fill=3 -> next cycle fill=0, issue_valid=0, outputs 0, err_count=0.
REQ-036 Issue 256 divide-by-zero commands -> err_count saturates at 255.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//   Buffers ALU commands in a small FIFO and presents them one at a time to a
//   downstream ALU through registered operand/opcode outputs. Adds are held on
//   the outputs for two cycles because the ALU needs two clocks for the carry.
//   Divide-by-zero commands are dropped at the FIFO head and counted.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   cmd_valid     upstream command present
//   cmd_ready     FIFO has room (depends on registered occupancy only)
//   cmd_opcode    3-bit ALU opcode of the incoming command
//   cmd_a, cmd_b  8-bit operands of the incoming command
//   operand1/2    registered operands to the ALU
//   opcode        registered opcode to the ALU
//   issue_valid   high on the first cycle a command is presented
//   div_zero_err  one-cycle pulse when a divide-by-zero command is dropped
//   err_count     saturating count of dropped commands
//   fill          current FIFO occupancy
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_opcode,
    input  logic [7:0]               cmd_a,
    input  logic [7:0]               cmd_b,
    output logic [7:0]               operand1,
    output logic [7:0]               operand2,
    output logic [2:0]               opcode,
    output logic                     issue_valid,
    output logic                     div_zero_err,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    state_t             r_state;
    logic [18:0]        r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [FILL_W-1:0]  r_fill;
    logic [7:0]         r_operand1;
    logic [7:0]         r_operand2;
    logic [2:0]         r_opcode;
    logic               r_issue_valid;
    logic               r_div_zero_err;
    logic [7:0]         r_err_count;

    logic               w_push;
    logic               w_pop;
    logic               w_dispatch_ok;
    logic [18:0]        w_head;
    logic [2:0]         w_head_op;
    logic [7:0]         w_head_a;
    logic [7:0]         w_head_b;
    logic               w_head_div0;

    assign cmd_ready = (r_fill < FILL_W'(DEPTH));
    assign w_push    = cmd_valid && cmd_ready;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_op   = w_head[18:16];
    assign w_head_a    = w_head[15:8];
    assign w_head_b    = w_head[7:0];
    assign w_head_div0 = (w_head_op == OP_DIV) && (w_head_b == 8'd0);

    // The only cycle that cannot take a new head is the first cycle of an add;
    // the HOLD cycle already dispatches so back-to-back adds issue every 2 cycles.
    assign w_dispatch_ok = !((r_state == ISSUE) && (r_opcode == OP_ADD));
    assign w_pop         = w_dispatch_ok && (r_fill != '0);

    // Storage is not reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_opcode, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_fill <= r_fill + FILL_W'(w_push) - FILL_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_operand1     <= '0;
            r_operand2     <= '0;
            r_opcode       <= '0;
            r_issue_valid  <= 1'b0;
            r_div_zero_err <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_issue_valid  <= 1'b0;
            r_div_zero_err <= 1'b0;
            case (r_state)
                ISSUE: begin
                    if (r_opcode == OP_ADD) begin
                        r_state <= HOLD;
                    end else if (w_pop && w_head_div0) begin
                        r_div_zero_err <= 1'b1;
                        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                        r_state <= IDLE;
                    end else if (w_pop) begin
                        r_operand1    <= w_head_a;
                        r_operand2    <= w_head_b;
                        r_opcode      <= w_head_op;
                        r_issue_valid <= 1'b1;
                        r_state       <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    // IDLE and the exit of HOLD both look at the FIFO head.
                    if (w_pop && w_head_div0) begin
                        r_div_zero_err <= 1'b1;
                        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                        r_state <= IDLE;
                    end else if (w_pop) begin
                        r_operand1    <= w_head_a;
                        r_operand2    <= w_head_b;
                        r_opcode      <= w_head_op;
                        r_issue_valid <= 1'b1;
                        r_state       <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign operand1     = r_operand1;
    assign operand2     = r_operand2;
    assign opcode       = r_opcode;
    assign issue_valid  = r_issue_valid;
    assign div_zero_err = r_div_zero_err;
    assign err_count    = r_err_count;
    assign fill         = r_fill;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int DEPTH = 4;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd_opcode = 3'd0;
    logic [7:0]     cmd_a = 8'd0;
    logic [7:0]     cmd_b = 8'd0;
    logic [7:0]     operand1;
    logic [7:0]     operand2;
    logic [2:0]     opcode;
    logic           issue_valid;
    logic           div_zero_err;
    logic [7:0]     err_count;
    logic [FW-1:0]  fill;

    alu_op_sequencer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .operand1     (operand1),
        .operand2     (operand2),
        .opcode       (opcode),
        .issue_valid  (issue_valid),
        .div_zero_err (div_zero_err),
        .err_count    (err_count),
        .fill         (fill)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of pending commands plus the values currently
    // presented to the ALU. An add blocks the next dispatch for one edge.
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    cmd_t       m_q[$];
    logic [7:0] m_op1, m_op2;
    logic [2:0] m_opc;
    logic       m_iv, m_dz;
    int         m_err;
    bit         m_block_next;
    bit         m_in_hold;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [2:0] op,
                              input logic [7:0] a, input logic [7:0] b);
        cmd_t e;
        bit   rdy;
        if (r) begin
            m_q.delete();
            m_op1 = 0; m_op2 = 0; m_opc = 0;
            m_iv = 0; m_dz = 0; m_err = 0;
            m_block_next = 0; m_in_hold = 0;
            return;
        end
        rdy = (m_q.size() < DEPTH);
        m_dz = 0;
        m_iv = 0;
        m_in_hold = 0;
        if (m_block_next) begin
            m_block_next = 0;
            m_in_hold = 1;
        end else if (m_q.size() > 0) begin
            e = m_q.pop_front();
            if (e.op == 3'd3 && e.b == 8'd0) begin
                m_dz = 1;
                if (m_err < 255) m_err++;
            end else begin
                m_op1 = e.a; m_op2 = e.b; m_opc = e.op;
                m_iv = 1;
                m_block_next = (e.op == 3'd0);
            end
        end
        if (v && rdy) begin
            e.op = op; e.a = a; e.b = b;
            m_q.push_back(e);
        end
    endtask

    task automatic check_all();
        check("issue_valid",  32'(issue_valid),  32'(m_iv));
        check("div_zero_err", 32'(div_zero_err), 32'(m_dz));
        check("err_count",    32'(err_count),    32'(m_err));
        check("fill",         32'(fill),         32'(m_q.size()));
        check("cmd_ready",    32'(cmd_ready),    32'(m_q.size() < DEPTH));
        check("operand1",     32'(operand1),     32'(m_op1));
        check("operand2",     32'(operand2),     32'(m_op2));
        check("opcode",       32'(opcode),       32'(m_opc));
    endtask

    task automatic step(input logic r, input logic v, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b);
        rst = r; cmd_valid = v; cmd_opcode = op; cmd_a = a; cmd_b = b;
        @(posedge clk);
        model_edge(r, v, op, a, b);
        cyc++;
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
    endtask

    initial begin
        int  iss_cyc[$];
        int  iss_opc[$];
        int  n_dz, n_iss, last_op2, accepted;
        bit  found;

        // Reset state
        step(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        step(1'b1, 1'b1, 3'd2, 8'd1, 8'd1);
        step(1'b0, 1'b0, 3'd0, 8'd0, 8'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_fill",  32'(fill),      32'd0);

        // xor into empty FIFO: issued two cycles after being presented
        step(1'b0, 1'b1, 3'd6, 8'h0F, 8'hFF);
        check("xor_not_yet", 32'(issue_valid), 32'd0);
        idle(1);
        check("xor_iv",  32'(issue_valid), 32'd1);
        check("xor_op1", 32'(operand1),    32'h0F);
        check("xor_op2", 32'(operand2),    32'hFF);
        check("xor_opc", 32'(opcode),      32'd6);
        idle(2);
        check("xor_held_op1", 32'(operand1), 32'h0F);

        // add then sub back-to-back
        step(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        step(1'b0, 1'b1, 3'd0, 8'd200, 8'd100);
        step(1'b0, 1'b1, 3'd1, 8'd5, 8'd3);
        if (issue_valid) begin iss_cyc.push_back(cyc); iss_opc.push_back(int'(opcode)); end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (issue_valid) begin iss_cyc.push_back(cyc); iss_opc.push_back(int'(opcode)); end
        end
        check("addsub_n_issue", 32'(iss_cyc.size()), 32'd2);
        if (iss_cyc.size() == 2) begin
            check("addsub_spacing", 32'(iss_cyc[1] - iss_cyc[0]), 32'd2);
            check("addsub_first",   32'(iss_opc[0]), 32'd0);
            check("addsub_second",  32'(iss_opc[1]), 32'd1);
        end

        // Fill to DEPTH behind consecutive adds
        step(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            step(1'b0, 1'b1, 3'd0, 8'($urandom), 8'($urandom));
            if (fill == FW'(DEPTH)) found = 1;
        end
        check("full_reached", 32'(found), 32'd1);
        for (int i = 0; i < 8; i++) begin
            if (fill == FW'(DEPTH)) check("full_not_ready", 32'(cmd_ready), 32'd0);
            step(1'b0, 1'b1, 3'd0, 8'($urandom), 8'($urandom));
        end
        idle(14);

        // div by zero dropped, valid div issued
        step(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        n_dz = 0; n_iss = 0; last_op2 = -1;
        step(1'b0, 1'b1, 3'd3, 8'd9, 8'd0);
        step(1'b0, 1'b1, 3'd3, 8'd9, 8'd3);
        for (int i = 0; i < 5; i++) begin
            if (div_zero_err) n_dz++;
            if (issue_valid) begin n_iss++; last_op2 = int'(operand2); end
            idle(1);
        end
        check("div0_pulses", 32'(n_dz),      32'd1);
        check("div0_err",    32'(err_count), 32'd1);
        check("div0_issues", 32'(n_iss),     32'd1);
        check("div0_op2",    32'(last_op2),  32'd3);

        // Reset during HOLD with three entries queued
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b1, 3'd0, 8'($urandom), 8'($urandom));
            if (m_in_hold && m_q.size() == 3) found = 1;
        end
        check("hold_fill3_reached", 32'(found), 32'd1);
        check("hold_fill3_dut", 32'(fill), 32'd3);
        step(1'b1, 1'b1, 3'd1, 8'd7, 8'd7);
        check("rsthold_fill", 32'(fill),        32'd0);
        check("rsthold_iv",   32'(issue_valid), 32'd0);
        check("rsthold_op1",  32'(operand1),    32'd0);
        check("rsthold_op2",  32'(operand2),    32'd0);
        check("rsthold_opc",  32'(opcode),      32'd0);
        check("rsthold_err",  32'(err_count),   32'd0);
        check("rsthold_rdy",  32'(cmd_ready),   32'd1);

        // 256 divide-by-zero commands saturate the error counter
        accepted = 0;
        for (int i = 0; i < 600 && accepted < 256; i++) begin
            if (cmd_ready) accepted++;
            step(1'b0, 1'b1, 3'd3, 8'($urandom), 8'd0);
        end
        check("sat_accepted", 32'(accepted), 32'd256);
        idle(6);
        check("sat_err", 32'(err_count), 32'd255);

        // Randomized traffic against the model
        step(1'b1, 1'b0, 3'd0, 8'd0, 8'd0);
        for (int i = 0; i < 400; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 3'($urandom), 8'($urandom), b);
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
